// File: rtl/hilo_muldiv_unit_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : hilo_muldiv_unit_pkg                                       |
// | Description : Shared ALU control codes and mult/div state encodings.     |
// |               MULDIV_UNSIGNED_EN makes ALU_multu / ALU_divu legal.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package hilo_muldiv_unit_pkg;

    localparam logic [4:0] ALU_mult  = 5'd24;
    localparam logic [4:0] ALU_div   = 5'd25;
    localparam logic [4:0] ALU_multu = 5'd26;
    localparam logic [4:0] ALU_divu  = 5'd27;

    typedef enum logic [0:0] {
        MULDIV_IDLE = 1'b0,
        MULDIV_RUN  = 1'b1
    } muldiv_state_t;

    function automatic logic is_legal_op(input logic [4:0] op);
`ifdef MULDIV_UNSIGNED_EN
        return (op == ALU_mult) || (op == ALU_div) || (op == ALU_multu) || (op == ALU_divu);
`else
        return (op == ALU_mult) || (op == ALU_div);
`endif
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_div) || (op == ALU_divu);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
`ifdef MULDIV_UNSIGNED_EN
        return (op == ALU_mult) || (op == ALU_div);
`else
        return 1'b1;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_muldiv_unit_core.sv
// +--------------------------------------------------------------------------+
// | Module      : hilo_muldiv_unit_core                                      |
// | Description : Iterative shift-add multiply / restoring divide datapath   |
// |               (the muldiv core) with its iteration counter.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module hilo_muldiv_unit_core
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int              CW     = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0]   c_last = CW'(ITERS - 1);

    muldiv_state_t      r_state, w_state_next;
    logic [CW-1:0]      r_count;
    logic               r_is_div, r_neg_q, r_neg_r, r_div_zero;
    logic [WIDTH-1:0]   r_a_raw, r_m, r_acc, r_q;
    logic [WIDTH-1:0]   w_acc_next, w_q_next, w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_sum, w_shift, w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_a_neg, w_b_neg;

    assign w_a_neg = is_signed & src_a[WIDTH-1];
    assign w_b_neg = is_signed & src_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -src_a : src_a;
    assign w_b_mag = w_b_neg ? -src_b : src_b;

    assign busy   = (r_state == MULDIV_RUN);
    assign finish = busy && (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) r_state <= MULDIV_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MULDIV_IDLE: if (start) w_state_next = MULDIV_RUN;
            MULDIV_RUN:  if (r_count == '0) w_state_next = MULDIV_IDLE;
            default:     w_state_next = MULDIV_IDLE;
        endcase
    end

    // One iteration: multiply shifts {acc,q} right after a conditional add;
    // divide shifts {acc,q} left and keeps the trial subtraction if it fits.
    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
        w_shift = {r_acc, r_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_m};
        if (r_is_div) begin
            if (!w_diff[WIDTH]) begin
                w_acc_next = w_diff[WIDTH-1:0];
                w_q_next   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_next = w_shift[WIDTH-1:0];
                w_q_next   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_next = w_sum[WIDTH:1];
            w_q_next   = {w_sum[0], r_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_prod = r_neg_q ? -{w_acc_next, w_q_next} : {w_acc_next, w_q_next};
        if (!r_is_div) begin
            res_hi = w_prod[2*WIDTH-1:WIDTH];
            res_lo = w_prod[WIDTH-1:0];
        end else if (r_div_zero) begin
            res_hi = r_a_raw;
            res_lo = '1;
        end else begin
            res_hi = r_neg_r ? -w_acc_next : w_acc_next;
            res_lo = r_neg_q ? -w_q_next : w_q_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_raw    <= '0;
            r_m        <= '0;
            r_acc      <= '0;
            r_q        <= '0;
        end else if (r_state == MULDIV_IDLE) begin
            if (start) begin
                r_count    <= c_last;
                r_is_div   <= is_div;
                r_neg_q    <= w_a_neg ^ w_b_neg;
                r_neg_r    <= w_a_neg;
                r_div_zero <= is_div && (src_b == '0);
                r_a_raw    <= src_a;
                r_m        <= is_div ? w_b_mag : w_a_mag;
                r_q        <= is_div ? w_a_mag : w_b_mag;
                r_acc      <= '0;
            end
        end else begin
            r_acc <= w_acc_next;
            r_q   <= w_q_next;
            if (r_count != '0) r_count <= r_count - CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : hilo_muldiv_unit                                           |
// | Description : HI/LO owner for the MIPS core: iterative mult/div, mthi/   |
// |               mtlo/mfhi/mflo and stall generation. MULDIV_UNSIGNED_EN    |
// |               enables multu/divu. ITERS must equal WIDTH.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    logic [WIDTH-1:0] r_hi, r_lo, w_res_hi, w_res_lo;
    logic             r_done, w_accept, w_finish, w_busy;

    assign w_accept = start & ~w_busy & is_legal_op(op);

    hilo_muldiv_unit_core #(
        .WIDTH (WIDTH),
        .ITERS (ITERS)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (w_accept),
        .is_div    (is_div_op(op)),
        .is_signed (is_signed_op(op)),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (w_busy),
        .finish    (w_finish),
        .res_hi    (w_res_hi),
        .res_lo    (w_res_lo)
    );

    // The requester holds mthi/mtlo through a stall, so writes are simply
    // dropped while busy and retried once the unit is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (!w_busy) begin
                if (wr_hi) r_hi <= wr_data;
                if (wr_lo) r_lo <= wr_data;
            end
        end
    end

`ifdef TEST_H
    always_ff @(posedge clk) begin
        if (!reset && start && !w_busy && !is_legal_op(op))
            $display("BAD MULDIV OPERATION CODE");
    end
`endif

    assign rd_data = rd_sel ? r_hi : r_lo;
    assign busy    = w_busy;
    assign done    = r_done;
    assign stall   = w_busy & (start | rd_en | wr_hi | wr_lo);

endmodule

`default_nettype wire
